sram_scan_ctrl: RTL and testbench



---
 rtl/sram_scan_pkg.sv | 69 ++++++
 rtl/sram_scan_shreg.sv | 41 ++++
 rtl/sram_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_sram_scan_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_scan_pkg.sv
// rtl/sram_scan_pkg.sv - shared state type, defaults and scan-word field map
// Purpose: common definitions for the SRAM scan-chain controller.
// Ports: none (package). Holds the FSM state enum, the default chain
// length and the bit offsets of every field in the packed scan word.
package sram_scan_pkg;

  localparam int SCAN_WIDTH_DEF = 112;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_LOAD      = 3'd4,
    ST_SHIFT_OUT = 3'd5,
    ST_RESP      = 3'd6
  } scan_state_t;

  // Field map of the scan word (port 0 in the upper half, port 1 below)
  localparam int SEL_MSB    = 111;
  localparam int SEL_LSB    = 108;
  localparam int ADDR0_MSB  = 107;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_MSB   = 91;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0_BIT   = 59;
  localparam int WEB0_BIT   = 58;
  localparam int WMASK0_MSB = 57;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_MSB  = 53;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_MSB   = 37;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1_BIT   = 5;
  localparam int WEB1_BIT   = 4;
  localparam int WMASK1_MSB = 3;
  localparam int WMASK1_LSB = 0;

  // Assemble a scan word from its individual fields
  function automatic logic [SCAN_WIDTH_DEF-1:0] pack_scan_word(
    input logic [3:0]  sel,
    input logic [15:0] addr0,
    input logic [31:0] din0,
    input logic        csb0,
    input logic        web0,
    input logic [3:0]  wmask0,
    input logic [15:0] addr1,
    input logic [31:0] din1,
    input logic        csb1,
    input logic        web1,
    input logic [3:0]  wmask1
  );
    logic [SCAN_WIDTH_DEF-1:0] w;
    w = '0;
    w[SEL_MSB:SEL_LSB]       = sel;
    w[ADDR0_MSB:ADDR0_LSB]   = addr0;
    w[DIN0_MSB:DIN0_LSB]     = din0;
    w[CSB0_BIT]              = csb0;
    w[WEB0_BIT]              = web0;
    w[WMASK0_MSB:WMASK0_LSB] = wmask0;
    w[ADDR1_MSB:ADDR1_LSB]   = addr1;
    w[DIN1_MSB:DIN1_LSB]     = din1;
    w[CSB1_BIT]              = csb1;
    w[WEB1_BIT]              = web1;
    w[WMASK1_MSB:WMASK1_LSB] = wmask1;
    return w;
  endfunction

endpackage

// File: rtl/sram_scan_shreg.sv
// rtl/sram_scan_shreg.sv - scan-word shift register
// Purpose: WIDTH-bit register with parallel load, MSB-out / LSB-in shift.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            load i_load_data (has priority over shift)
//   i_load_data       parallel load value
//   i_shift           shift left by one, i_shift_bit enters at bit 0
//   i_shift_bit       serial input bit
//   o_q               current register contents
//   o_msb             bit WIDTH-1, the next bit to leave the register
module sram_scan_shreg
  import sram_scan_pkg::*;
#(
  parameter int WIDTH = SCAN_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_shift_bit,
  output logic [WIDTH-1:0] o_q,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_shift_bit};
    end
  end

  assign o_q   = r_data;
  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/sram_scan_ctrl.sv
// rtl/sram_scan_ctrl.sv - scan-chain access controller for an SRAM macro
// Purpose: accepts one packed scan word per request, shifts it into the
// SRAM scan chain, pulses global_csb, and for reads loads the macro output
// back into the chain and shifts it out into the response word.
// Optional feature: define SCAN_COMPARE_EN to compare read data against the
// request word and count mismatches; otherwise mismatch outputs are 0.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_read, req_word          1 = read / 0 = write, packed scan word
//   rsp_valid/rsp_ready         response handshake
//   rsp_word                    write: request word, read: captured chain
//   scan_out, scan_en           serial data into the chain, shift enable
//   sram_load, global_csb       chain load strobe, macro select (low)
//   scan_in                     serial data from the chain
//   mismatch, mismatch_cnt      read-compare flag and saturating count
module sram_scan_ctrl
  import sram_scan_pkg::*;
#(
  parameter int SCAN_WIDTH = SCAN_WIDTH_DEF,
  parameter int CSB_CYCLES = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic [SCAN_WIDTH-1:0] req_word,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SCAN_WIDTH-1:0] rsp_word,
  output logic                  scan_out,
  output logic                  scan_en,
  output logic                  sram_load,
  output logic                  global_csb,
  input  logic                  scan_in,
  output logic                  mismatch,
  output logic [7:0]            mismatch_cnt
);

  localparam int CW = $clog2(SCAN_WIDTH + 1);

  scan_state_t           r_state;
  scan_state_t           w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_init;
  logic                  w_cnt_load;
  logic                  w_cnt_zero;
  logic                  r_req_read;
  logic [SCAN_WIDTH-1:0] r_req_word;
  logic                  r_rsp_valid;
  logic [SCAN_WIDTH-1:0] r_rsp_word;
  logic                  w_accept;
  logic                  w_rsp_capture;
  logic                  w_sh_load;
  logic                  w_sh_shift;
  logic                  w_sh_bit;
  logic [SCAN_WIDTH-1:0] w_sh_q;
  logic                  w_sh_msb;

  sram_scan_shreg #(
    .WIDTH(SCAN_WIDTH)
  ) u_shreg (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_load      (w_sh_load),
    .i_load_data (req_word),
    .i_shift     (w_sh_shift),
    .i_shift_bit (w_sh_bit),
    .o_q         (w_sh_q),
    .o_msb       (w_sh_msb)
  );

  // r_cnt holds the number of cycles remaining in the current state
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_read  <= 1'b0;
      r_req_word  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_word  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_cnt_load) begin
        r_cnt <= w_cnt_init;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_accept) begin
        r_req_read <= req_read;
        r_req_word <= req_word;
      end
      // The first RESP cycle registers the response, so the word presented
      // with rsp_valid is held in its own register and cannot move.
      if (w_rsp_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_word  <= r_req_read ? w_sh_q : r_req_word;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_cnt_load    = 1'b0;
    w_cnt_init    = '0;
    w_accept      = 1'b0;
    w_rsp_capture = 1'b0;
    w_sh_load     = 1'b0;
    w_sh_shift    = 1'b0;
    w_sh_bit      = 1'b0;
    req_ready     = 1'b0;
    scan_en       = 1'b0;
    scan_out      = 1'b0;
    sram_load     = 1'b0;
    global_csb    = 1'b1;

    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_sh_load    = 1'b1;
          w_next_state = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        scan_en    = 1'b1;
        scan_out   = w_sh_msb;
        w_sh_shift = 1'b1;
        if (w_cnt_zero) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        global_csb = 1'b0;
        if (w_cnt_zero) begin
          w_next_state = r_req_read ? ST_CAPTURE : ST_RESP;
        end
      end
      ST_CAPTURE: begin
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        sram_load    = 1'b1;
        w_next_state = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        scan_en    = 1'b1;
        w_sh_shift = 1'b1;
        w_sh_bit   = scan_in;
        if (w_cnt_zero) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_capture = !r_rsp_valid;
        if (r_rsp_valid && rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Reload the cycle counter on every state change
    w_cnt_load = (w_next_state != r_state);
    case (w_next_state)
      ST_SHIFT_IN, ST_SHIFT_OUT: w_cnt_init = CW'(SCAN_WIDTH - 1);
      ST_ACCESS:                 w_cnt_init = CW'(CSB_CYCLES - 1);
      default:                   w_cnt_init = '0;
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_word  = r_rsp_word;

`ifdef SCAN_COMPARE_EN
  logic       r_mismatch;
  logic [7:0] r_mismatch_cnt;
  logic       w_diff;

  assign w_diff = r_req_read && (w_sh_q != r_req_word);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= 8'd0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
    end else if (w_rsp_capture && w_diff) begin
      r_mismatch <= 1'b1;
      if (r_mismatch_cnt != 8'hFF) begin
        r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
      end
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_mismatch_cnt;
`else
  assign mismatch     = 1'b0;
  assign mismatch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// tb/tb_sram_scan_ctrl.sv - scoreboard bench for sram_scan_ctrl
module tb_sram_scan_ctrl;
  import sram_scan_pkg::*;

  localparam int W      = 112;
  localparam int CSB    = 1;
  localparam int CSB3   = 3;
  localparam int LAT_WR = W + CSB + 1;
  localparam int LAT_RD = 2 * W + CSB + 3;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_read = 1'b0;
  logic [W-1:0] req_word = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_word;
  logic         scan_out;
  logic         scan_en;
  logic         sram_load;
  logic         global_csb;
  logic         scan_in;
  logic         mismatch;
  logic [7:0]   mismatch_cnt;

  logic         req_valid_3 = 1'b0;
  logic         req_ready_3;
  logic         req_read_3 = 1'b0;
  logic [W-1:0] req_word_3 = '0;
  logic         rsp_valid_3;
  logic         rsp_ready_3 = 1'b1;
  logic [W-1:0] rsp_word_3;
  logic         scan_out_3;
  logic         scan_en_3;
  logic         sram_load_3;
  logic         global_csb_3;
  logic         scan_in_3 = 1'b0;
  logic         mismatch_3;
  logic [7:0]   mismatch_cnt_3;

  sram_scan_ctrl #(.SCAN_WIDTH(W), .CSB_CYCLES(CSB)) u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_word(req_word),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
    .scan_out(scan_out), .scan_en(scan_en), .sram_load(sram_load), .global_csb(global_csb),
    .scan_in(scan_in), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  sram_scan_ctrl #(.SCAN_WIDTH(W), .CSB_CYCLES(CSB3)) u_dut3 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_read(req_read_3), .req_word(req_word_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_word(rsp_word_3),
    .scan_out(scan_out_3), .scan_en(scan_en_3), .sram_load(sram_load_3), .global_csb(global_csb_3),
    .scan_in(scan_in_3), .mismatch(mismatch_3), .mismatch_cnt(mismatch_cnt_3)
  );

  typedef struct {
    logic [W-1:0] word;
    int           acc_edge;
    int           lat;
    logic         mm;
    logic [7:0]   mmc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           ecnt = 0;
  int           n_issued = 0;
  int           n_done = 0;
  logic [W-1:0] chain;
  logic [W-1:0] cur_flip = '0;
  logic [W-1:0] cur_word = '0;
  bit           bp_hold = 1'b0;
  bit           bp_rand = 1'b0;
  logic [7:0]   exp_mmc = 8'd0;

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) ecnt <= ecnt + 1;

  // Scan chain: shifts while scan_en, and on sram_load captures what the
  // macro would present (the shifted-in word, optionally corrupted).
  always @(posedge wb_clk_i) begin
    if (sram_load) chain <= chain ^ cur_flip;
    else if (scan_en) chain <= {chain[W-2:0], scan_out};
  end
  assign scan_in = chain[W-1];

  always @(posedge wb_clk_i) begin
    #1;
    if (bp_hold) rsp_ready = 1'b0;
    else if (bp_rand) rsp_ready = 1'($urandom_range(0, 1));
    else rsp_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at edge %0d", name, ecnt);
  endtask

  // Monitor: protocol runs and scoreboard comparison, sampled on negedge
  logic prev_rv = 1'b0;
  int   csb_run = 0;
  int   en_run  = 0;
  int   ld_run  = 0;
  bit   have_cur = 1'b0;
  exp_t cur;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      csb_run = 0; en_run = 0; ld_run = 0; prev_rv = 1'b0; have_cur = 1'b0;
    end else begin
      if (!global_csb) begin
        if (csb_run == 0) chk("chain_shifted_in", chain, cur_word);
        csb_run++;
      end else if (csb_run != 0) begin
        chk("csb_low_cycles", W'(csb_run), W'(CSB));
        csb_run = 0;
      end
      if (scan_en) en_run++;
      else if (en_run != 0) begin
        chk("scan_en_cycles", W'(en_run), W'(W));
        en_run = 0;
      end
      if (sram_load) ld_run++;
      else if (ld_run != 0) begin
        chk("sram_load_cycles", W'(ld_run), W'(1));
        ld_run = 0;
      end
      if (rsp_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid at edge %0d, required none", ecnt);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          chk("rsp_latency", W'(ecnt - cur.acc_edge), W'(cur.lat));
          chk("mismatch", W'(mismatch), W'(cur.mm));
          chk("mismatch_cnt", W'(mismatch_cnt), W'(cur.mmc));
        end
      end
      if (rsp_valid && have_cur) begin
        chk("rsp_word", rsp_word, cur.word);
        chk("req_ready_in_resp", W'(req_ready), W'(0));
        if (rsp_ready) begin
          n_done++;
          have_cur = 1'b0;
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic issue(input logic rd, input logic [W-1:0] word, input logic [W-1:0] flip);
    int   t;
    exp_t e;
    t = 0;
    while (req_ready !== 1'b1 && t < 2000) begin
      @(posedge wb_clk_i); #1;
      t++;
    end
    if (req_ready !== 1'b1) begin
      timeout("req_ready_wait");
      return;
    end
    cur_flip  = flip;
    req_valid = 1'b1;
    req_read  = rd;
    req_word  = word;
    @(posedge wb_clk_i); #1;
    req_valid = 1'b0;
    cur_word  = word;
    e.word     = rd ? (word ^ flip) : word;
    e.acc_edge = ecnt;
    e.lat      = rd ? LAT_RD : LAT_WR;
`ifdef SCAN_COMPARE_EN
    e.mm = rd && (flip != '0);
    if (e.mm && exp_mmc != 8'hFF) exp_mmc++;
`else
    e.mm = 1'b0;
`endif
    e.mmc = exp_mmc;
    sb.push_back(e);
    n_issued++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (n_done != n_issued && t < 5000) begin
      @(posedge wb_clk_i); #1;
      t++;
    end
    if (n_done != n_issued) timeout("drain");
  endtask

  logic [W-1:0] one = 1;

  initial begin
    logic [W-1:0] w_wr;
    logic [W-1:0] w_rd;
    logic [W-1:0] w_rand;
    logic [W-1:0] flip;
    logic         rd;
    int           t;
    int           acc;
    int           low3;
    int           falls3;
    logic         prev_csb3;

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_word", rsp_word, '0);
    chk("rst_scan_en", W'(scan_en), W'(0));
    chk("rst_scan_out", W'(scan_out), W'(0));
    chk("rst_sram_load", W'(sram_load), W'(0));
    chk("rst_global_csb", W'(global_csb), W'(1));
    chk("rst_mismatch", W'(mismatch), W'(0));
    chk("rst_mismatch_cnt", W'(mismatch_cnt), W'(0));
    wb_rst_i = 1'b0;

    w_wr = pack_scan_word(4'd0, 16'd1, 32'd0, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    w_rd = pack_scan_word(4'd8, 16'd1, 32'hDEADBEEF, 1'b0, 1'b1, 4'h0, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    issue(1'b0, w_wr, '0);
    issue(1'b1, w_rd, '0);
    issue(1'b1, w_rd, one << 60);
    drain();

    // Backpressure: hold rsp_ready low with a competing request present
    bp_hold = 1'b1;
    issue(1'b0, {W{1'b1}} ^ w_rd, '0);
    t = 0;
    while (!rsp_valid && t < 1000) begin
      @(posedge wb_clk_i); #1;
      t++;
    end
    if (!rsp_valid) timeout("bp_rsp_wait");
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_read  = 1'b1;
      req_word  = w_wr ^ {W{1'b1}};
      chk("bp_rsp_valid_held", W'(rsp_valid), W'(1));
      @(posedge wb_clk_i); #1;
    end
    req_valid = 1'b0;
    bp_hold   = 1'b0;
    drain();
    issue(1'b0, w_wr ^ (one << 7), '0);
    drain();

    // Randomised traffic with random backpressure and corrupted reads
    bp_rand = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rd = 1'($urandom_range(0, 1));
      for (int i = 0; i < W; i++) w_rand[i] = 1'($urandom_range(0, 1));
      flip = '0;
      if (rd && $urandom_range(0, 1) == 1) flip = one << $urandom_range(0, W - 1);
      issue(rd, w_rand, flip);
    end
    drain();
    bp_rand = 1'b0;

    // Reset during SHIFT_OUT cycle 50 of a read
    issue(1'b1, w_rd, '0);
    t = 0;
    while (!sram_load && t < 1000) begin
      @(posedge wb_clk_i); #1;
      t++;
    end
    if (!sram_load) timeout("sram_load_wait");
    repeat (50) begin
      @(posedge wb_clk_i); #1;
    end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("abort_global_csb", W'(global_csb), W'(1));
    chk("abort_scan_en", W'(scan_en), W'(0));
    chk("abort_rsp_valid", W'(rsp_valid), W'(0));
    chk("abort_req_ready", W'(req_ready), W'(1));
    chk("abort_mismatch_cnt", W'(mismatch_cnt), W'(0));
    wb_rst_i = 1'b0;
    sb.delete();
    exp_mmc  = 8'd0;
    n_issued = n_done;
    repeat (300) @(posedge wb_clk_i);
    #1;
    issue(1'b0, w_wr, '0);
    drain();

    // CSB_CYCLES = 3 instance: single write
    req_valid_3 = 1'b1;
    req_word_3  = w_rd;
    @(posedge wb_clk_i); #1;
    req_valid_3 = 1'b0;
    acc    = ecnt;
    low3   = 0;
    falls3 = 0;
    prev_csb3 = 1'b1;
    t = 0;
    while (!rsp_valid_3 && t < 500) begin
      if (!global_csb_3) low3++;
      if (!global_csb_3 && prev_csb3) falls3++;
      prev_csb3 = global_csb_3;
      @(posedge wb_clk_i); #1;
      t++;
    end
    if (!rsp_valid_3) timeout("csb3_rsp_wait");
    chk("csb3_low_cycles", W'(low3), W'(CSB3));
    chk("csb3_pulses", W'(falls3), W'(1));
    chk("csb3_latency", W'(ecnt - acc), W'(W + CSB3 + 1));
    chk("csb3_rsp_word", rsp_word_3, w_rd);
    repeat (3) @(posedge wb_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
